// File: rtl/pss_pkg.sv
// Shared types and constants for the picture snapshot sequencer:
// FSM state encoding, register offset table and the timed-out read fill value.
package pss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PUBLISH
    } pss_state_e;

    localparam int PSS_NUM_OFFSETS = 5;

    // Snapshot list, in issue order, relative to the sampled register base.
    localparam logic [31:0] OFFSETS [PSS_NUM_OFFSETS] = '{
        32'h0000_1111,
        32'h0000_1122,
        32'h0000_1133,
        32'h0000_1411,
        32'h0000_2111
    };

    localparam int                          PSS_FILL_MAX_W = 256;
    localparam logic [PSS_FILL_MAX_W-1:0] TIMEOUT_FILL   = '1;

endpackage

// File: rtl/pss_wait_timer.sv
// Read-response wait timer: cleared on a grant, counts while enabled and
// saturates at TIMEOUT, where expired stays high until the next clear.
module pss_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic ARESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT));

    always_ff @(posedge CLK or posedge ARESET) begin
        if (ARESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/picture_snapshot_sequencer.sv
// On each picture_start rising edge, reads a fixed register list over a
// single-outstanding read port and publishes the words atomically to snap_data.
module picture_snapshot_sequencer
    import pss_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                         CLK,
    input  logic                         ARESET,
    input  logic                         picture_start,
    input  logic [ADDR_W-1:0]            reg_base,
    output logic                         rd_req,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_gnt,
    input  logic                         rd_rvalid,
    input  logic [DATA_W-1:0]            rd_rdata,
    output logic [NUM_REGS*DATA_W-1:0]   snap_data,
    output logic                         snap_done,
    output logic                         busy,
    output logic                         err_timeout,
    output logic                         err_overrun
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    pss_state_e          state;
    logic                start_prev;
    logic                start_edge;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    next_idx;
    logic [DATA_W-1:0]   work [NUM_REGS];
    logic                timer_clear;
    logic                timer_en;
    logic                timer_expired;
    logic                word_done;
    logic [DATA_W-1:0]   word_value;

    assign start_edge  = picture_start & ~start_prev;
    assign next_idx    = idx + IDX_W'(1);
    assign timer_clear = (state == ST_REQ) && rd_gnt;
    assign timer_en    = (state == ST_WAIT);
    // Returned data beats an expiry landing in the same cycle.
    assign word_done   = (state == ST_WAIT) && (rd_rvalid || timer_expired);
    assign word_value  = rd_rvalid ? rd_rdata : TIMEOUT_FILL[DATA_W-1:0];

    pss_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .CLK     (CLK),
        .ARESET  (ARESET),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // NOTE: the working buffer has no reset; every entry is rewritten before
    // PUBLISH reads it, and only the reset snap_data register is ever visible.
    always_ff @(posedge CLK) begin
        if (word_done) begin
            work[idx] <= word_value;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below sees the pre-edge values of state, idx and base_q.
    always_ff @(posedge CLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            start_prev  <= 1'b0;
            base_q      <= '0;
            idx         <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            snap_data   <= '0;
            snap_done   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            start_prev  <= picture_start;
            snap_done   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= start_edge && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        base_q  <= reg_base;
                        idx     <= '0;
                        rd_addr <= reg_base + ADDR_W'(OFFSETS[0]);
                        rd_req  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd_gnt) begin
                        rd_req <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (word_done) begin
                        err_timeout <= !rd_rvalid;
                        if (idx == IDX_W'(NUM_REGS - 1)) begin
                            state <= ST_PUBLISH;
                        end else begin
                            idx     <= next_idx;
                            rd_addr <= base_q + ADDR_W'(OFFSETS[next_idx]);
                            rd_req  <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_PUBLISH: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        snap_data[i*DATA_W +: DATA_W] <= work[i];
                    end
                    snap_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picture_snapshot_sequencer.sv
// Scoreboard bench: stimulus queues expected reads and snapshots; a negedge
// monitor plays the register slave and pops/compares on every DUT output event.
module tb_picture_snapshot_sequencer;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 5;
    localparam int TIMEOUT  = 255;
    localparam int SNAP_W   = NUM_REGS * DATA_W;

    logic                CLK = 1'b0;
    logic                ARESET = 1'b1;
    logic                picture_start = 1'b0;
    logic [ADDR_W-1:0]   reg_base = '0;
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_gnt = 1'b0;
    logic                rd_rvalid = 1'b0;
    logic [DATA_W-1:0]   rd_rdata = '0;
    logic [SNAP_W-1:0]   snap_data;
    logic                snap_done;
    logic                busy;
    logic                err_timeout;
    logic                err_overrun;

    picture_snapshot_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .ARESET        (ARESET),
        .picture_start (picture_start),
        .reg_base      (reg_base),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_rvalid     (rd_rvalid),
        .rd_rdata      (rd_rdata),
        .snap_data     (snap_data),
        .snap_done     (snap_done),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; int req_len; } exp_rd_t;
    typedef struct { int gnt_wait; bit drop; logic [31:0] data; } rsp_t;
    typedef struct { logic [SNAP_W-1:0] data; int due; } exp_snap_t;

    exp_rd_t   exp_rd_q[$];
    rsp_t      rsp_q[$];
    exp_snap_t exp_snap_q[$];

    logic [31:0] tb_offsets [NUM_REGS] = '{32'h1111, 32'h1122, 32'h1133, 32'h1411, 32'h2111};

    int total = 0;
    int bad   = 0;
    int grant_cnt = 0;
    int snap_cnt  = 0;
    int tmo_cnt   = 0;
    int ovr_cnt   = 0;

    task automatic check(input string name, input logic [SNAP_W-1:0] act, input logic [SNAP_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + register slave.
    int          req_len = 0;
    bit          pending = 0;
    bit          addr_moved = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] first_addr = '0;

    always @(negedge CLK) begin
        exp_rd_t   er;
        exp_snap_t es;
        rsp_t      rs;
        rd_gnt    = 1'b0;
        rd_rvalid = 1'b0;
        if (ARESET) begin
            req_len    = 0;
            pending    = 0;
            addr_moved = 0;
        end else begin
            if (snap_done) begin
                snap_cnt++;
                check("snap_expected", SNAP_W'(exp_snap_q.size() != 0), SNAP_W'(1));
                if (exp_snap_q.size() != 0) begin
                    es = exp_snap_q.pop_front();
                    check("snap_data", snap_data, es.data);
                    if (es.due >= 0) check("snap_latency", SNAP_W'(cyc), SNAP_W'(es.due));
                end
            end
            if (err_timeout) tmo_cnt++;
            if (err_overrun) ovr_cnt++;

            if (pending) begin
                rd_rvalid = 1'b1;
                rd_rdata  = pend_data;
                pending   = 0;
            end else if (rd_req) begin
                if (req_len == 0) first_addr = rd_addr;
                else if (rd_addr !== first_addr) addr_moved = 1;
                req_len++;
                if (rsp_q.size() == 0 || req_len > rsp_q[0].gnt_wait) begin
                    rd_gnt = 1'b1;
                    grant_cnt++;
                    check("read_expected", SNAP_W'(exp_rd_q.size() != 0), SNAP_W'(1));
                    if (exp_rd_q.size() != 0) begin
                        er = exp_rd_q.pop_front();
                        check("rd_addr", SNAP_W'(rd_addr), SNAP_W'(er.addr));
                        check("req_len", SNAP_W'(req_len), SNAP_W'(er.req_len));
                        check("addr_stable", SNAP_W'(addr_moved), SNAP_W'(0));
                    end
                    if (rsp_q.size() != 0) begin
                        rs        = rsp_q.pop_front();
                        pending   = !rs.drop;
                        pend_data = rs.data;
                    end
                    req_len    = 0;
                    addr_moved = 0;
                end
            end
        end
    end

    // Queue the five reads, slave responses and (optionally) the snapshot.
    task automatic push_seq(input logic [31:0] base, input logic [31:0] data0,
                            input int stall_idx, input int stall, input int drop_idx,
                            input bit want_snap, input int due);
        logic [SNAP_W-1:0] snap = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            logic [31:0] word;
            word = (i == drop_idx) ? 32'hFFFF_FFFF : data0 + 32'(i);
            snap[i*DATA_W +: DATA_W] = word;
            exp_rd_q.push_back('{addr: base + tb_offsets[i], req_len: (i == stall_idx) ? stall + 1 : 1});
            rsp_q.push_back('{gnt_wait: (i == stall_idx) ? stall : 0, drop: (i == drop_idx), data: data0 + 32'(i)});
        end
        if (want_snap) exp_snap_q.push_back('{data: snap, due: due});
    endtask

    task automatic wait_snaps(input int target, input int budget);
        int n = 0;
        while (snap_cnt < target && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check("snap_count", SNAP_W'(snap_cnt), SNAP_W'(target));
    endtask

    initial begin
        int n0, g0, t0, o0, n;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_ctrl", SNAP_W'({rd_req, busy, snap_done, err_timeout, err_overrun}), SNAP_W'(0));
        check("reset_addr", SNAP_W'(rd_addr), SNAP_W'(0));
        check("reset_snap", snap_data, SNAP_W'(0));
        ARESET = 1'b0;
        repeat (2) @(posedge CLK);

        // Basic sweep
        #1;
        reg_base = 32'h4000_0000;
        picture_start = 1'b1;
        push_seq(32'h4000_0000, 32'hA0, -1, 0, -1, 1, cyc + 12);
        @(posedge CLK); #1;
        picture_start = 1'b0;
        check("busy_after_edge", SNAP_W'(busy), SNAP_W'(1));
        wait_snaps(1, 100);
        check("busy_after_done", SNAP_W'(busy), SNAP_W'(0));
        check("reads_left_basic", SNAP_W'(exp_rd_q.size()), SNAP_W'(0));

        // Backpressure: grant held off 3 cycles on the second read
        repeat (3) @(posedge CLK);
        #1;
        picture_start = 1'b1;
        push_seq(32'h4000_0000, 32'hB0, 1, 3, -1, 1, cyc + 15);
        @(posedge CLK); #1;
        picture_start = 1'b0;
        wait_snaps(2, 100);

        // Timeout on the third read
        repeat (3) @(posedge CLK);
        #1;
        t0 = tmo_cnt;
        picture_start = 1'b1;
        push_seq(32'h4000_0000, 32'hC0, -1, 0, 2, 1, -1);
        @(posedge CLK); #1;
        picture_start = 1'b0;
        wait_snaps(3, 600);
        check("timeout_pulses", SNAP_W'(tmo_cnt - t0), SNAP_W'(1));

        // Overrun: second edge three cycles after the first
        repeat (3) @(posedge CLK);
        #1;
        o0 = ovr_cnt;
        g0 = grant_cnt;
        picture_start = 1'b1;
        push_seq(32'h4000_0000, 32'hD0, -1, 0, -1, 1, cyc + 12);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        picture_start = 1'b0;
        @(posedge CLK); #1;
        picture_start = 1'b1;
        @(posedge CLK); #1;
        picture_start = 1'b0;
        wait_snaps(4, 100);
        repeat (20) @(posedge CLK);
        #1;
        check("overrun_pulses", SNAP_W'(ovr_cnt - o0), SNAP_W'(1));
        check("overrun_reads", SNAP_W'(grant_cnt - g0), SNAP_W'(5));
        check("overrun_snaps", SNAP_W'(snap_cnt), SNAP_W'(4));

        // Reset during the third WAIT (third response withheld)
        repeat (3) @(posedge CLK);
        #1;
        g0 = grant_cnt;
        picture_start = 1'b1;
        push_seq(32'h4000_0000, 32'hE0, -1, 0, 2, 0, -1);
        @(posedge CLK); #1;
        picture_start = 1'b0;
        n = 0;
        while (grant_cnt < g0 + 3 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        check("third_grant_seen", SNAP_W'(grant_cnt - g0), SNAP_W'(3));
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("busy_before_reset", SNAP_W'(busy), SNAP_W'(1));
        ARESET = 1'b1;
        #1;
        check("midreset_ctrl", SNAP_W'({rd_req, busy, snap_done, err_timeout, err_overrun}), SNAP_W'(0));
        check("midreset_addr", SNAP_W'(rd_addr), SNAP_W'(0));
        check("midreset_snap", snap_data, SNAP_W'(0));
        @(posedge CLK); #1;
        exp_rd_q.delete();
        rsp_q.delete();
        ARESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        picture_start = 1'b1;
        push_seq(32'h4000_0000, 32'hF0, -1, 0, -1, 1, cyc + 12);
        @(posedge CLK); #1;
        picture_start = 1'b0;
        wait_snaps(5, 100);

        // Address wrap with picture_start held high
        repeat (3) @(posedge CLK);
        #1;
        g0 = grant_cnt;
        n0 = snap_cnt;
        reg_base = 32'hFFFF_F000;
        picture_start = 1'b1;
        push_seq(32'hFFFF_F000, 32'h10, -1, 0, -1, 1, cyc + 12);
        repeat (100) @(posedge CLK);
        #1;
        picture_start = 1'b0;
        check("level_reads", SNAP_W'(grant_cnt - g0), SNAP_W'(5));
        check("level_snaps", SNAP_W'(snap_cnt - n0), SNAP_W'(1));
        repeat (5) @(posedge CLK);
        #1;
        check("final_reads_left", SNAP_W'(exp_rd_q.size()), SNAP_W'(0));
        check("final_snaps_left", SNAP_W'(exp_snap_q.size()), SNAP_W'(0));
        check("final_timeouts", SNAP_W'(tmo_cnt), SNAP_W'(1));
        check("final_overruns", SNAP_W'(ovr_cnt), SNAP_W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/picture_snapshot_sequencer.md
Name: picture_snapshot_sequencer

Overview:
- On each rising edge of picture_start, issues a fixed, ordered list of register reads over a single-outstanding read-master port.
- Captures the returned words into a working buffer, then publishes them atomically to snap_data with a one-cycle snap_done pulse.
- snap_done is the coverage sample trigger.
- Sits between the picture-control logic and the register bus; sequences the bus on the sampler's behalf.

Parameters:
- ADDR_W, 32, read address width.
- DATA_W, 32, read data width.
- NUM_REGS, 5, number of registers in the snapshot list (must match the package offset table length).
- TIMEOUT, 255, maximum cycles waiting for rd_rvalid after a grant.

Ports:
- CLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- picture_start  in  1  level input; the rising edge starts a snapshot.
- reg_base  in  ADDR_W  register block base address; sampled on the start edge.
- rd_req  out  1  read request.
- rd_addr  out  ADDR_W  read address; stable while rd_req is high.
- rd_gnt  in  1  request accepted in the cycle where rd_req and rd_gnt are both high.
- rd_rvalid  in  1  read data valid.
- rd_rdata  in  DATA_W  read data.
- snap_data  out  NUM_REGS*DATA_W  published snapshot; entry i occupies bits [i*DATA_W +: DATA_W].
- snap_done  out  1  one-cycle pulse when snap_data updates.
- busy  out  1  high from the start edge until snap_done.
- err_timeout  out  1  one-cycle pulse per timed-out read.
- err_overrun  out  1  one-cycle pulse when a start edge arrives while busy.

Behaviour:
- Reset: all outputs 0, snap_data 0, state IDLE, start-edge register 0, index 0.
- Edge detect: registered copy of picture_start; start_edge = picture_start & ~prev.
- States: IDLE, REQ, WAIT, PUBLISH.
- IDLE:
  - On start_edge, latch reg_base and set idx=0.
  - Go to REQ; busy=1 from the next cycle.
  - rd_req rises in the cycle after the edge cycle.
- REQ:
  - rd_req=1, rd_addr = base_q + OFFSETS[idx], using ADDR_W-bit wrap-around addition.
  - Stay in REQ until rd_gnt=1.
  - On the grant cycle, rd_req drops on the next edge; clear the timer; go to WAIT.
- WAIT:
  - rd_rvalid=1: store rd_rdata in work[idx].
  - Timer reaches TIMEOUT with no rd_rvalid: store all-ones in work[idx] and pulse err_timeout.
  - Either way, if idx==NUM_REGS-1 go to PUBLISH; otherwise idx++ and go to REQ.
- PUBLISH:
  - Copy work to snap_data in a single cycle.
  - Pulse snap_done, clear busy, return to IDLE.
- Latency: with zero-wait grant and data the cycle after grant, snap_done occurs 1 + 2*NUM_REGS + 1 cycles after the start edge.
- rd_rvalid outside WAIT is ignored.
- rd_rvalid in the same cycle as rd_gnt is not accepted; data is taken from the following cycle onward.
- A start edge while busy:
  - Pulses err_overrun.
  - Does not restart or alter the sequence.
  - Is not queued.
- rd_rvalid and timer expiry in the same cycle: data wins, no err_timeout.
- snap_data changes only in PUBLISH; partial snapshots are never visible.
- ARESET mid-sequence:
  - Immediate return to reset values; rd_req deasserts asynchronously.
  - The outstanding read response is discarded because the FSM is in IDLE.
- picture_start held high does not retrigger; a new low-to-high transition is required.

Decomposition:
- Package pss_pkg holds:
  - state enum pss_state_e;
  - localparam array OFFSETS = {0x1111, 0x1122, 0x1133, 0x1411, 0x2111} (NUM_REGS=5);
  - the TIMEOUT fill value (all ones).
- Sub-module pss_wait_timer: counter with clear/enable and an expired flag, width $clog2(TIMEOUT+1).

Test Plan:
- Basic sweep:
  - Stimulus: reg_base=0x4000_0000, immediate grant, rvalid the cycle after grant with data 0xA0..0xA4.
  - Required: addresses 0x4000_1111, 0x4000_1122, 0x4000_1133, 0x4000_1411, 0x4000_2111 in order; snap_data entries 0xA0..0xA4; one snap_done 12 cycles after the edge.
- Backpressure: rd_gnt held low 3 cycles on the 2nd read -> rd_req and rd_addr 0x4000_1122 stay stable 4 cycles; final snapshot unchanged.
- Timeout: no rvalid for the 3rd read -> err_timeout pulses once after 255 cycles; entry 2 = 0xFFFF_FFFF; other entries correct; snap_done still fires.
- Overrun: second picture_start edge 3 cycles after the first -> one err_overrun pulse; exactly five reads; one snap_done.
- Reset mid-sequence: ARESET during the 3rd WAIT -> all outputs 0 immediately, snap_data 0; the next start edge runs a full clean sequence.
- Wrap and level: reg_base=0xFFFF_F000 -> first address 0x0000_0111; picture_start held high 100 cycles -> only one sequence.
